// File: rtl/axi_vid_pkg.sv
// ------------------------------------------------------------------
// axi_vid_pkg : AXI4 constants shared by the video DDR read path
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package axi_vid_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // AxSIZE encoding is log2 of the bytes per beat.
  function automatic logic [2:0] arsize_f(input int unsigned data_width);
    int unsigned bytes;
    logic [2:0]  sz;
    bytes = data_width / 8;
    sz    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((32'd1 << i) == bytes) sz = 3'(i);
    end
    return sz;
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_addr_gen.sv
// ------------------------------------------------------------------
// frame_addr_gen : frame byte address and remaining-beat tracker
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module frame_addr_gen
  import axi_vid_pkg::*;
#(
  parameter int unsigned               ADDR_WIDTH  = 28,
  parameter int unsigned               DATA_WIDTH  = 256,
  parameter logic [ADDR_WIDTH-1:0]     BASE_ADDR   = '0,
  parameter int unsigned               FRAME_BEATS = 259200,
  parameter int unsigned               BEATS_W     = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  adv_i,
  input  logic [8:0]            len_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [BEATS_W-1:0]    beats_left_o,
  output logic                  last_o
);

  localparam int unsigned SHIFT = int'(arsize_f(DATA_WIDTH));

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BEATS_W-1:0]    left_q, left_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= BASE_ADDR;
      left_q <= '0;
    end else begin
      addr_q <= addr_d;
      left_q <= left_d;
    end
  end

  // Load wins over advance so a restart discards the finishing burst.
  always_comb begin
    addr_d = addr_q;
    left_d = left_q;
    if (load_i) begin
      addr_d = BASE_ADDR;
      left_d = BEATS_W'(FRAME_BEATS);
    end else if (adv_i) begin
      addr_d = addr_q + (ADDR_WIDTH'(len_i) << SHIFT);
      if (32'(left_q) > 32'(len_i)) left_d = left_q - BEATS_W'(len_i);
      else                          left_d = '0;
    end
  end

  assign addr_o       = addr_q;
  assign beats_left_o = left_q;
  assign last_o       = (32'(left_q) <= 32'(len_i));

endmodule

`default_nettype wire

// File: rtl/axi_rd_burst_master.sv
// ------------------------------------------------------------------
// axi_rd_burst_master : AXI4 INCR-burst frame reader into output FIFO
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module axi_rd_burst_master
  import axi_vid_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 28,
  parameter int unsigned           DATA_WIDTH  = 256,
  parameter int unsigned           ID_WIDTH    = 4,
  parameter int unsigned           ARID_VAL    = 0,
  parameter int unsigned           BURST_LEN   = 16,
  parameter int unsigned           FIFO_DEPTH  = 512,
  parameter int unsigned           LVL_WIDTH   = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           FRAME_BEATS = 259200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  input  logic                  fifo_wr_full,
  input  logic [LVL_WIDTH-1:0]  fifo_water_level,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  output logic [ID_WIDTH-1:0]   m_arid,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  output logic                  frame_done,
  output logic                  rd_err
);

  localparam int unsigned BEATS_W = $clog2(FRAME_BEATS + 1);
  localparam int unsigned LVL_MAX = FIFO_DEPTH - BURST_LEN;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ADDR  = 2'd2;
  localparam logic [1:0] S_DATA  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic [8:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic                  pend_q, pend_d;

  logic                  w_load, w_adv, w_last, w_rready, w_beat, w_restart, w_level_ok;
  logic [8:0]            w_cur_len, w_next_len;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [BEATS_W-1:0]    w_left;

  frame_addr_gen #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .BASE_ADDR   (BASE_ADDR),
    .FRAME_BEATS (FRAME_BEATS),
    .BEATS_W     (BEATS_W)
  ) u_gen (
    .clk          (clk),
    .rst          (rst),
    .load_i       (w_load),
    .adv_i        (w_adv),
    .len_i        (w_cur_len),
    .addr_o       (w_addr),
    .beats_left_o (w_left),
    .last_o       (w_last)
  );

  assign w_cur_len  = {1'b0, arlen_q} + 9'd1;
  assign w_next_len = (32'(w_left) < BURST_LEN) ? 9'(w_left) : 9'(BURST_LEN);
  assign w_level_ok = (32'(fifo_water_level) <= LVL_MAX);
  assign w_restart  = pend_q | frame_start;
  assign w_beat     = m_rvalid & w_rready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      arvalid_q <= 1'b0;
      araddr_q  <= BASE_ADDR;
      arlen_q   <= 8'd0;
      cnt_q     <= 9'd0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      done_q    <= done_d;
      pend_q    <= pend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    done_d    = 1'b0;
    pend_d    = pend_q;
    w_load    = 1'b0;
    w_adv     = 1'b0;
    if (frame_start) err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          w_load  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_restart) begin
          w_load = 1'b1;
          pend_d = 1'b0;
        end else if (w_level_ok) begin
          arvalid_d = 1'b1;
          araddr_d  = w_addr;
          arlen_d   = 8'(w_next_len - 9'd1);
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (frame_start) pend_d = 1'b1;
        if (m_arready) begin
          arvalid_d = 1'b0;
          cnt_d     = 9'd0;
          state_d   = S_DATA;
        end
      end
      default: begin
        if (frame_start) pend_d = 1'b1;
        if (w_beat) begin
          cnt_d = cnt_q + 9'd1;
          if (m_rresp != RESP_OKAY) err_d = 1'b1;
          // RLAST must coincide exactly with the arlen-th beat.
          if (m_rlast != (cnt_q == {1'b0, arlen_q})) err_d = 1'b1;
          if (m_rlast) begin
            if (w_restart) begin
              w_load  = 1'b1;
              pend_d  = 1'b0;
              state_d = S_WAIT;
            end else if (w_last) begin
              w_adv   = 1'b1;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              w_adv   = 1'b1;
              state_d = S_WAIT;
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    w_rready     = (state_q == S_DATA) & ~fifo_wr_full;
    m_rready     = w_rready;
    fifo_wr_en   = m_rvalid & w_rready;
    fifo_wr_data = m_rdata;
    m_arvalid    = arvalid_q;
    m_araddr     = araddr_q;
    m_arlen      = arlen_q;
    m_arsize     = arsize_f(DATA_WIDTH);
    m_arburst    = BURST_INCR;
    m_arid       = ID_WIDTH'(ARID_VAL);
    frame_done   = done_q;
    rd_err       = err_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_rd_burst_master.sv
// ------------------------------------------------------------------
// tb_axi_rd_burst_master : randomized bench with frame-level reference
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_axi_rd_burst_master;

  localparam int AW = 28, DW = 256, IW = 4, BL = 16, FD = 512, LW = 10, FB = 40;
  localparam int BYTES = DW / 8;
  localparam logic [AW-1:0] BASE = '0;

  logic          clk, rst, frame_start;
  logic          fifo_wr_en, fifo_wr_full;
  logic [DW-1:0] fifo_wr_data, m_rdata;
  logic [LW-1:0] fifo_water_level;
  logic [AW-1:0] m_araddr;
  logic [7:0]    m_arlen;
  logic [2:0]    m_arsize;
  logic [1:0]    m_arburst, m_rresp;
  logic [IW-1:0] m_arid;
  logic          m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic          frame_done, rd_err;

  int checks = 0, failures = 0, done_cnt = 0;

  axi_rd_burst_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .ARID_VAL(0),
    .BURST_LEN(BL), .FIFO_DEPTH(FD), .LVL_WIDTH(LW),
    .BASE_ADDR(BASE), .FRAME_BEATS(FB)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_wr_full(fifo_wr_full),
    .fifo_water_level(fifo_water_level),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arid(m_arid), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
    .m_rready(m_rready), .frame_done(frame_done), .rd_err(rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    #3;
    if (frame_done === 1'b1) done_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Called and returning at negedge+1.
  task automatic pulse_fs();
    frame_start = 1'b1;
    @(negedge clk); #1;
    frame_start = 1'b0;
    chk_val("rd_err_clr", rd_err, 0);
  endtask

  task automatic do_ar(input logic [AW-1:0] ea, input logic [7:0] el, input int stall);
    int t = 0;
    while (m_arvalid !== 1'b1 && t < 300) begin
      @(negedge clk); #1; t++;
    end
    chk_val("ar_timeout", t < 300, 1);
    chk_val("araddr", m_araddr, ea);
    chk_val("arlen", m_arlen, el);
    chk_val("arsize", m_arsize, 3'd5);
    chk_val("arburst", m_arburst, 2'b01);
    chk_val("arid", m_arid, 0);
    chk_val("rready_in_addr", m_rready, 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk); #1;
      chk_val("arvalid_hold", m_arvalid, 1);
      chk_val("araddr_hold", m_araddr, ea);
      chk_val("arlen_hold", m_arlen, el);
    end
    m_arready = 1'b1;
    @(negedge clk); #1;
    m_arready = 1'b0;
    chk_val("arvalid_drop", m_arvalid, 0);
  endtask

  task automatic do_r(input int last_at, input int bad_idx, input int fs_idx, input bit rnd,
                      input int full_lo, input int full_hi, output int got);
    int idx = 0, cyc = 0;
    bit fs_sent = 0, fin = 0, vld, full;
    logic [DW-1:0] d;
    while (!fin && cyc < 400) begin
      vld  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      full = rnd ? ($urandom_range(0, 4) == 0) : (cyc >= full_lo && cyc <= full_hi);
      for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
      m_rvalid     = vld;
      fifo_wr_full = full;
      m_rdata      = d;
      m_rresp      = (idx == bad_idx) ? 2'b10 : 2'b00;
      m_rlast      = (idx == last_at);
      frame_start  = (!fs_sent && idx == fs_idx);
      if (frame_start) fs_sent = 1;
      #1;
      chk_val("rready", m_rready, !full);
      chk_val("wr_en", fifo_wr_en, vld && !full);
      if (vld && !full) chk_val("wr_data", fifo_wr_data, d);
      chk_val("done_in_burst", frame_done, 0);
      @(posedge clk);
      if (vld && !full) begin
        if (idx == last_at) fin = 1;
        idx++;
      end
      cyc++;
      @(negedge clk); #1;
    end
    m_rvalid = 0; m_rlast = 0; fifo_wr_full = 0; frame_start = 0; m_rresp = 0;
    chk_val("r_timeout", fin, 1);
    got = idx;
  endtask

  // Reference: the frame is FB beats cut into BL-beat bursts at consecutive addresses.
  task automatic run_frame(input bit rnd, input int stall0, input int flo, input int fhi,
                           input int err_b, input int bad_idx, input int early_at);
    int rem = FB, b = 0, len, last, got;
    logic [AW-1:0] a = BASE;
    bit err_seen = 0;
    while (rem > 0) begin
      len  = (rem < BL) ? rem : BL;
      last = (b == err_b && early_at >= 0) ? early_at : len - 1;
      if (rnd) fifo_water_level = LW'($urandom_range(0, FD - BL));
      do_ar(a, 8'(len - 1), (b == 0) ? stall0 : (rnd ? int'($urandom_range(0, 4)) : 0));
      do_r(last, (b == err_b) ? bad_idx : -1, -1, rnd, (b == 0) ? flo : -1, (b == 0) ? fhi : -1, got);
      chk_val("beats", got, last + 1);
      if (b == err_b) err_seen = 1;
      chk_val("rd_err", rd_err, err_seen);
      a += AW'(len * BYTES);
      rem -= len;
      b++;
    end
    chk_val("frame_done", frame_done, 1);
    @(negedge clk); #1;
    chk_val("frame_done_pulse", frame_done, 0);
  endtask

  initial begin
    int got;
    rst = 1; frame_start = 0; fifo_wr_full = 0; fifo_water_level = '0;
    m_arready = 0; m_rdata = '0; m_rresp = 0; m_rlast = 0; m_rvalid = 0;
    repeat (3) @(negedge clk);
    #1;
    chk_val("rst_arvalid", m_arvalid, 0);
    chk_val("rst_rready", m_rready, 0);
    chk_val("rst_wr_en", fifo_wr_en, 0);
    chk_val("rst_done", frame_done, 0);
    chk_val("rst_err", rd_err, 0);
    chk_val("rst_araddr", m_araddr, BASE);
    chk_val("rst_arlen", m_arlen, 0);
    rst = 0;
    repeat (3) begin
      @(negedge clk); #1;
      chk_val("idle_no_ar", m_arvalid, 0);
    end

    // Plain frame: 16+16+8 beats
    pulse_fs();
    run_frame(0, 0, -1, -1, -1, -1, -1);
    chk_val("done_cnt1", done_cnt, 1);

    // Water-level gate, AR stall and FIFO-full window
    fifo_water_level = 10'd497;
    pulse_fs();
    repeat (8) begin
      chk_val("no_ar_hi_level", m_arvalid, 0);
      @(negedge clk); #1;
    end
    fifo_water_level = 10'd496;
    chk_val("no_ar_same_cycle", m_arvalid, 0);
    @(negedge clk); #1;
    chk_val("ar_at_496", m_arvalid, 1);
    fifo_water_level = '0;
    run_frame(0, 5, 4, 6, -1, -1, -1);
    chk_val("done_cnt2", done_cnt, 2);

    // Restart during beat 7 of burst 2
    pulse_fs();
    do_ar(BASE, 8'd15, 0);
    do_r(15, -1, -1, 0, -1, -1, got);
    do_ar(BASE + AW'(BL * BYTES), 8'd15, 0);
    do_r(15, -1, 7, 0, -1, -1, got);
    chk_val("restart_beats", got, 16);
    run_frame(0, 0, -1, -1, -1, -1, -1);
    chk_val("done_cnt3", done_cnt, 3);

    // Restart coincident with the frame's final RLAST
    pulse_fs();
    do_ar(BASE, 8'd15, 0);
    do_r(15, -1, -1, 0, -1, -1, got);
    do_ar(BASE + AW'(BL * BYTES), 8'd15, 0);
    do_r(15, -1, -1, 0, -1, -1, got);
    do_ar(BASE + AW'(2 * BL * BYTES), 8'd7, 0);
    do_r(7, -1, 7, 0, -1, -1, got);
    chk_val("coinc_no_done", frame_done, 0);
    run_frame(0, 0, -1, -1, -1, -1, -1);
    chk_val("done_cnt4", done_cnt, 4);

    // Error response on one beat, then early RLAST (14 beats of a len-15 burst)
    pulse_fs();
    run_frame(1, 2, -1, -1, 0, 3, -1);
    chk_val("err_sticky_end", rd_err, 1);
    pulse_fs();
    run_frame(1, 0, -1, -1, 1, -1, 13);
    chk_val("err_early_end", rd_err, 1);
    chk_val("done_cnt6", done_cnt, 6);

    // Randomized frames
    for (int f = 0; f < 4; f++) begin
      pulse_fs();
      run_frame(1, int'($urandom_range(0, 4)), -1, -1, -1, -1, -1);
    end
    chk_val("done_cnt_final", done_cnt, 10);
    chk_val("err_final", rd_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
